// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: per-stage stall vector, multi-cycle EX hold,
// flush/redirect pulse, and stall/flush performance counters.
module pipe_ctrl #(
    parameter int MC_W   = 6,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              mc_start,
    input  logic [MC_W-1:0]   mc_len,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [7:0]        flush_count
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_MCYC  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [5:0]      STALL_EX = 6'b001111;
    localparam logic [5:0]      STALL_ID = 6'b000111;
    localparam logic [MC_W-1:0] CNT_ONE  = MC_W'(1);

    logic [1:0]        state_q, state_d;
    logic [MC_W-1:0]   cnt_q, cnt_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic [PERF_W-1:0] stall_cycles_q;
    logic [7:0]        flush_count_q;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
    endfunction

    // Stall is combinational from state and requests; forced quiet while in reset.
    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            case (state_q)
                S_RUN: begin
                    if (stallreq_ex)      stall = STALL_EX;
                    else if (stallreq_id) stall = STALL_ID;
                end
                S_MCYC:  stall = STALL_EX;
                default: stall = 6'b000000;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = new_pc_q;
        case (state_q)
            S_RUN: begin
                if (flush_req) begin
                    state_d  = S_FLUSH;
                    new_pc_d = flush_pc;
                end else if (mc_start && (mc_len != '0)) begin
                    state_d = S_MCYC;
                    cnt_d   = mc_len;
                end
            end
            S_MCYC: begin
                if (flush_req) begin
                    state_d  = S_FLUSH;
                    cnt_d    = '0;
                    new_pc_d = flush_pc;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FLUSH: begin
                if (flush_req) begin
                    new_pc_d = flush_pc;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_RUN;
            cnt_q          <= '0;
            new_pc_q       <= 32'h0;
            stall_cycles_q <= '0;
            flush_count_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            new_pc_q <= new_pc_d;
            if (stall != 6'b000000) stall_cycles_q <= sat_inc(stall_cycles_q);
            if (state_q == S_FLUSH) flush_count_q  <= flush_count_q + 8'd1;
        end
    end

    assign flush        = (state_q == S_FLUSH);
    assign mc_busy      = (state_q == S_MCYC);
    assign new_pc       = new_pc_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected outputs queued with stimulus,
// popped and compared on the falling edge; counters tracked by a small model.
module tb_pipe_ctrl;

    typedef struct packed {
        logic        id;
        logic        ex;
        logic        mcs;
        logic [5:0]  mcl;
        logic        fr;
        logic [31:0] fpc;
    } stim_t;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        mc_start;
    logic [5:0]  mc_len;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic [3:0]  stall_cycles;
    logic [7:0]  flush_count;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] m_sc  = 4'h0;
    logic [7:0] m_fc  = 8'h00;

    pipe_ctrl #(.MC_W(6), .PERF_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mc_start     (mc_start),
        .mc_len       (mc_len),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk_s(input logic id, input logic ex, input logic mcs,
                                   input logic [5:0] mcl, input logic fr, input logic [31:0] fpc);
        return {id, ex, mcs, mcl, fr, fpc};
    endfunction

    function automatic exp_t mk_e(input logic [5:0] st, input logic fl, input logic [31:0] pc,
                                  input logic busy);
        return {st, fl, pc, busy};
    endfunction

    task automatic drive(input stim_t s);
        stallreq_id = s.id;
        stallreq_ex = s.ex;
        mc_start    = s.mcs;
        mc_len      = s.mcl;
        flush_req   = s.fr;
        flush_pc    = s.fpc;
    endtask

    task automatic test_reset();
        drive(mk_s(1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 32'hDEAD_BEEF));
        rst = 1'b0;
        #3;
        n_cmp++;
        if ({stall, flush, new_pc, mc_busy, stall_cycles, flush_count} !== '0) begin
            n_err++;
            $display("FAIL reset_initial got stall=%b flush=%b pc=%h busy=%b sc=%h fc=%h, want all zero",
                     stall, flush, new_pc, mc_busy, stall_cycles, flush_count);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({stall, flush, new_pc, mc_busy, stall_cycles, flush_count} !== '0) begin
            n_err++;
            $display("FAIL reset_held got stall=%b flush=%b pc=%h busy=%b sc=%h fc=%h, want all zero",
                     stall, flush, new_pc, mc_busy, stall_cycles, flush_count);
        end
        @(posedge clk); #1;
        drive(mk_s(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0));
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_hazard();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk_s(1, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b000111, 0, 32'h0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        st.push_back(mk_s(1, 1, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b001111, 0, 32'h0, 0));
        st.push_back(mk_s(0, 1, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b001111, 0, 32'h0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, flush, new_pc, mc_busy} !== e) begin
                n_err++;
                $display("FAIL hazard[%0d] got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                         i, stall, flush, new_pc, mc_busy, e.stall, e.flush, e.pc, e.busy);
            end
            n_cmp++;
            if ({stall_cycles, flush_count} !== {m_sc, m_fc}) begin
                n_err++;
                $display("FAIL hazard_cnt[%0d] got sc=%h fc=%h, want sc=%h fc=%h", i, stall_cycles, flush_count, m_sc, m_fc);
            end
            if (e.stall != 6'b0 && m_sc != 4'hF) m_sc++;
            if (e.flush) m_fc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multicycle();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk_s(0, 0, 1, 3, 0, 0)); exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b001111, 0, 32'h0, 1));
        st.push_back(mk_s(1, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b001111, 0, 32'h0, 1));
        st.push_back(mk_s(0, 0, 1, 5, 0, 0)); exp_q.push_back(mk_e(6'b001111, 0, 32'h0, 1));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        st.push_back(mk_s(0, 0, 1, 0, 0, 0)); exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, flush, new_pc, mc_busy} !== e) begin
                n_err++;
                $display("FAIL multicycle[%0d] got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                         i, stall, flush, new_pc, mc_busy, e.stall, e.flush, e.pc, e.busy);
            end
            n_cmp++;
            if ({stall_cycles, flush_count} !== {m_sc, m_fc}) begin
                n_err++;
                $display("FAIL multicycle_cnt[%0d] got sc=%h fc=%h, want sc=%h fc=%h", i, stall_cycles, flush_count, m_sc, m_fc);
            end
            if (e.stall != 6'b0 && m_sc != 4'hF) m_sc++;
            if (e.flush) m_fc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk_s(0, 0, 1, 10, 0, 0));          exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0));           exp_q.push_back(mk_e(6'b001111, 0, 32'h0, 1));
        st.push_back(mk_s(0, 0, 0, 0, 1, 32'h100));     exp_q.push_back(mk_e(6'b001111, 0, 32'h0, 1));
        st.push_back(mk_s(0, 1, 1, 4, 0, 32'hAAAA));    exp_q.push_back(mk_e(6'b000000, 1, 32'h100, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0));           exp_q.push_back(mk_e(6'b000000, 0, 32'h100, 0));
        st.push_back(mk_s(1, 0, 0, 0, 0, 0));           exp_q.push_back(mk_e(6'b000111, 0, 32'h100, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, flush, new_pc, mc_busy} !== e) begin
                n_err++;
                $display("FAIL abort[%0d] got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                         i, stall, flush, new_pc, mc_busy, e.stall, e.flush, e.pc, e.busy);
            end
            n_cmp++;
            if ({stall_cycles, flush_count} !== {m_sc, m_fc}) begin
                n_err++;
                $display("FAIL abort_cnt[%0d] got sc=%h fc=%h, want sc=%h fc=%h", i, stall_cycles, flush_count, m_sc, m_fc);
            end
            if (e.stall != 6'b0 && m_sc != 4'hF) m_sc++;
            if (e.flush) m_fc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  e;
        st.push_back(mk_s(0, 1, 1, 5, 1, 32'h180));     exp_q.push_back(mk_e(6'b001111, 0, 32'h100, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0));           exp_q.push_back(mk_e(6'b000000, 1, 32'h180, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0));           exp_q.push_back(mk_e(6'b000000, 0, 32'h180, 0));
        st.push_back(mk_s(0, 0, 0, 0, 1, 32'h200));     exp_q.push_back(mk_e(6'b000000, 0, 32'h180, 0));
        st.push_back(mk_s(0, 0, 0, 0, 1, 32'h300));     exp_q.push_back(mk_e(6'b000000, 1, 32'h200, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0));           exp_q.push_back(mk_e(6'b000000, 1, 32'h300, 0));
        st.push_back(mk_s(0, 0, 0, 0, 0, 0));           exp_q.push_back(mk_e(6'b000000, 0, 32'h300, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, flush, new_pc, mc_busy} !== e) begin
                n_err++;
                $display("FAIL back_to_back[%0d] got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                         i, stall, flush, new_pc, mc_busy, e.stall, e.flush, e.pc, e.busy);
            end
            n_cmp++;
            if ({stall_cycles, flush_count} !== {m_sc, m_fc}) begin
                n_err++;
                $display("FAIL back_to_back_cnt[%0d] got sc=%h fc=%h, want sc=%h fc=%h", i, stall_cycles, flush_count, m_sc, m_fc);
            end
            if (e.stall != 6'b0 && m_sc != 4'hF) m_sc++;
            if (e.flush) m_fc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            drive(mk_s(0, 1, 0, 0, 0, 0));
            exp_q.push_back(mk_e(6'b001111, 0, 32'h300, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, flush, new_pc, mc_busy} !== e) begin
                n_err++;
                $display("FAIL saturation[%0d] got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                         i, stall, flush, new_pc, mc_busy, e.stall, e.flush, e.pc, e.busy);
            end
            if (e.stall != 6'b0 && m_sc != 4'hF) m_sc++;
            @(posedge clk); #1;
        end
        drive(mk_s(0, 0, 0, 0, 0, 0));
        n_cmp++;
        if (stall_cycles !== 4'hF) begin
            n_err++;
            $display("FAIL stall_cycles_saturated got %h, want f", stall_cycles);
        end
    endtask

    task automatic test_async_reset();
        drive(mk_s(0, 0, 1, 10, 0, 0));
        @(posedge clk); #1;
        drive(mk_s(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mc_busy !== 1'b1 || stall !== 6'b001111) begin
            n_err++;
            $display("FAIL async_pre_busy got busy=%b stall=%b, want busy=1 stall=001111", mc_busy, stall);
        end
        #2;
        stallreq_ex = 1'b1;
        rst = 1'b0;
        m_sc = 4'h0;
        m_fc = 8'h00;
        #1;
        n_cmp++;
        if ({stall, flush, new_pc, mc_busy, stall_cycles, flush_count} !== '0) begin
            n_err++;
            $display("FAIL async_reset got stall=%b flush=%b pc=%h busy=%b sc=%h fc=%h, want all zero",
                     stall, flush, new_pc, mc_busy, stall_cycles, flush_count);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk_s(0, 0, 1, 0, 0, 0));
        @(negedge clk);
        n_cmp++;
        if (stall !== 6'b000000 || mc_busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_release_len0 got stall=%b busy=%b, want stall=000000 busy=0", stall, mc_busy);
        end
        @(posedge clk); #1;
        drive(mk_s(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        n_cmp++;
        if (stall !== 6'b000000 || mc_busy !== 1'b0 || stall_cycles !== 4'h0) begin
            n_err++;
            $display("FAIL async_after_len0 got stall=%b busy=%b sc=%h, want stall=000000 busy=0 sc=0",
                     stall, mc_busy, stall_cycles);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_wrap();
        exp_t e;
        for (int i = 0; i < 259; i++) begin
            if (i < 257) drive(mk_s(0, 0, 0, 0, 1, 32'(i + 1)));
            else         drive(mk_s(0, 0, 0, 0, 0, 0));
            if (i == 0)        exp_q.push_back(mk_e(6'b000000, 0, 32'h0, 0));
            else if (i <= 257) exp_q.push_back(mk_e(6'b000000, 1, 32'(i), 0));
            else               exp_q.push_back(mk_e(6'b000000, 0, 32'd257, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, flush, new_pc, mc_busy} !== e) begin
                n_err++;
                $display("FAIL flush_wrap[%0d] got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                         i, stall, flush, new_pc, mc_busy, e.stall, e.flush, e.pc, e.busy);
            end
            if (e.flush) m_fc++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (flush_count !== 8'h01) begin
            n_err++;
            $display("FAIL flush_count_wrap got %h, want 01", flush_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout, simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hazard();
        test_multicycle();
        test_abort();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        test_flush_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
